gc_rx_multi: RTL and testbench
==============================

GC_RX_MULTI -- requirements
Module: gc_rx_multi

Interface
REQ-001 SHALL provide parameter CHANNELS, default 4, number of independent controller ports (1..4).
REQ-002 SHALL provide parameter SAMPLE_DELAY, default 200, clk cycles from line falling edge to bit sample point.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 2000, idle clk cycles in ARMED before abort.
REQ-004 SHALL provide port clk, input, 1, system clock; all logic rising-edge.
REQ-005 SHALL provide port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL provide port data_in, input, CHANNELS, raw asynchronous controller data lines, one per channel.
REQ-007 SHALL provide port send, input, CHANNELS, high while the transmitter drives that channel.
REQ-008 SHALL provide port mode, input, CHANNELS, per channel: 0 = 64-bit button frame, 1 = 24-bit ID frame.
REQ-009 SHALL provide port rx_data, output, 64*CHANNELS, last button frame; channel n at [64n+63:64n].
REQ-010 SHALL provide port rx_id, output, 24*CHANNELS, last ID frame; channel n at [24n+23:24n].
REQ-011 SHALL provide port data_valid, output, CHANNELS, one-cycle pulse on rx_data update.
REQ-012 SHALL provide port id_valid, output, CHANNELS, one-cycle pulse on rx_id update.
REQ-013 SHALL provide port rx_timeout, output, CHANNELS, one-cycle pulse on frame abort.
REQ-014 SHALL provide port busy, output, CHANNELS, high whenever channel state is not IDLE.

Function
REQ-015 SHALL pass each data_in bit through a 3-flop synchronizer (s1, s2, s3); falling edge = s2 low and s3 high.
REQ-016 SHALL run one FSM per channel with states IDLE, ARMED, SAMPLE; channels fully independent.
REQ-017 SHALL, in any state, on send high: go to ARMED, clear bit counter, shift register, timeout counter and sample counter.
REQ-018 SHALL, in ARMED with send low, on falling edge: go to SAMPLE with sample counter = 1.
REQ-019 SHALL increment the sample counter each SAMPLE cycle; at SAMPLE_DELAY it captures s3 into shift LSB, shifts left, increments the bit counter.
REQ-020 SHALL treat frame length as 64 (mode 0) or 24 (mode 1), mode sampled on the cycle send falls.
REQ-021 SHALL, on capturing the final bit, register the full frame (first bit at MSB) into rx_data or rx_id on that same edge, pulse the matching valid concurrently, return to IDLE.
REQ-022 SHALL, after a non-final bit, return to ARMED and reset the timeout counter.
REQ-023 SHALL ignore falling edges in IDLE and while send is high.
REQ-024 SHALL leave rx_data/rx_id unchanged on abort, timeout, or send reasserted mid-frame.
REQ-025 SHALL size counters to hold SAMPLE_DELAY, TIMEOUT_CYCLES and 64 without wrap.

Reset
REQ-026 SHALL on rst set all FSMs to IDLE, clear counters and synchronizers to 1 (line idle-high).
REQ-027 SHALL on rst set each rx_data lane to 64'h8080808080800000 (neutral sticks), rx_id to 0, all pulse outputs and busy to 0.
REQ-028 SHALL let rst override send and data_in in the same cycle, aborting any frame in progress without pulses.

Configuration
REQ-029 SHALL compile the timeout feature only when GC_RX_TIMEOUT_EN is defined.
REQ-030 SHALL with GC_RX_TIMEOUT_EN count ARMED cycles with send low; at TIMEOUT_CYCLES pulse rx_timeout and go to IDLE.
REQ-031 SHALL without GC_RX_TIMEOUT_EN tie rx_timeout to 0 and hold ARMED indefinitely until edge, send or rst.

Verification
REQ-032 SHALL cover: ch0 mode 0, send pulse then 64 bits encoding 64'h0080_7F80_8080_1A2B -> rx_data lane0 equals value, data_valid[0] one cycle, other lanes 64'h8080808080800000.
REQ-033 SHALL cover: ch1 mode 1, 24 bits 24'h0A0B0C -> rx_id lane1 = 24'h0A0B0C, id_valid[1] one pulse, rx_data lane1 unchanged.
REQ-034 SHALL cover: ch2 and ch3 frames with simultaneous falling edges -> both lanes correct, pulses same cycle.
REQ-035 SHALL cover (GC_RX_TIMEOUT_EN): 10 bits then line stays high 2000 cycles -> rx_timeout[0] pulse, busy[0] low, rx_data unchanged.
REQ-036 SHALL cover: rst asserted after 30 bits -> busy low next cycle, no valid pulses, rx_data = 64'h8080808080800000.
REQ-037 SHALL cover: send reasserted after 40 bits then full 64-bit frame -> only second frame reported, one data_valid pulse.

Source files
------------

// File: rtl/gc_rx_multi.sv
// gc_rx_multi: multi-channel GameCube-style controller frame receiver.
// Each channel synchronises its data line, detects falling edges and samples
// the line SAMPLE_DELAY cycles after each edge, assembling 64-bit button
// frames (mode 0) or 24-bit ID frames (mode 1), first bit at the MSB.
// Optional feature: define GC_RX_TIMEOUT_EN to abort frames whose line stays
// idle for TIMEOUT_CYCLES cycles while waiting for the next bit.
module gc_rx_multi #(
    parameter int CHANNELS       = 4,
    parameter int SAMPLE_DELAY   = 200,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNELS-1:0]      data_in,
    input  logic [CHANNELS-1:0]      send,
    input  logic [CHANNELS-1:0]      mode,
    output logic [64*CHANNELS-1:0]   rx_data,
    output logic [24*CHANNELS-1:0]   rx_id,
    output logic [CHANNELS-1:0]      data_valid,
    output logic [CHANNELS-1:0]      id_valid,
    output logic [CHANNELS-1:0]      rx_timeout,
    output logic [CHANNELS-1:0]      busy
);

    localparam int SW = $clog2(SAMPLE_DELAY + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [63:0] NEUTRAL = 64'h8080808080800000;

    typedef enum logic [1:0] {IDLE, ARMED, SAMPLE} state_t;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [2:0]    r_sync;      // [0]=s1, [1]=s2, [2]=s3
            state_t        r_state;
            logic [SW-1:0] r_samp;
            logic [6:0]    r_bits;
            logic [62:0]   r_shift;
            logic          r_send_d;
            logic          r_len24;
            logic [63:0]   r_data;
            logic [23:0]   r_id;
            logic          r_dv;
            logic          r_iv;
            logic          w_fall;
            logic [63:0]   w_shift_next;
            logic [6:0]    w_bits_next;
            logic          w_last;
`ifdef GC_RX_TIMEOUT_EN
            logic [TW-1:0] r_tcnt;
            logic          r_to;
`endif

            assign w_fall       = !r_sync[1] && r_sync[2];
            assign w_shift_next = {r_shift, r_sync[2]};
            assign w_bits_next  = r_bits + 7'd1;
            assign w_last       = (w_bits_next == (r_len24 ? 7'd24 : 7'd64));

            // Three-flop synchroniser; idles high like the physical line.
            always_ff @(posedge clk) begin
                if (rst) r_sync <= 3'b111;
                else     r_sync <= {r_sync[1:0], data_in[gi]};
            end

            // Latch the frame length on the cycle the transmitter releases the line.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_send_d <= 1'b0;
                    r_len24  <= 1'b0;
                end else begin
                    r_send_d <= send[gi];
                    if (r_send_d && !send[gi]) r_len24 <= mode[gi];
                end
            end

            // Per-channel receive FSM with registered frame outputs and pulses.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= IDLE;
                    r_samp  <= '0;
                    r_bits  <= '0;
                    r_shift <= '0;
                    r_data  <= NEUTRAL;
                    r_id    <= '0;
                    r_dv    <= 1'b0;
                    r_iv    <= 1'b0;
`ifdef GC_RX_TIMEOUT_EN
                    r_tcnt  <= '0;
                    r_to    <= 1'b0;
`endif
                end else begin
                    r_dv <= 1'b0;
                    r_iv <= 1'b0;
`ifdef GC_RX_TIMEOUT_EN
                    r_to <= 1'b0;
`endif
                    if (send[gi]) begin
                        // Transmitter owns the line: restart reception from scratch.
                        r_state <= ARMED;
                        r_samp  <= '0;
                        r_bits  <= '0;
                        r_shift <= '0;
`ifdef GC_RX_TIMEOUT_EN
                        r_tcnt  <= '0;
`endif
                    end else begin
                        case (r_state)
                            IDLE: r_state <= IDLE;
                            ARMED: begin
                                if (w_fall) begin
                                    r_state <= SAMPLE;
                                    r_samp  <= SW'(1);
                                end
`ifdef GC_RX_TIMEOUT_EN
                                else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                                    r_to    <= 1'b1;
                                    r_state <= IDLE;
                                end else begin
                                    r_tcnt <= r_tcnt + TW'(1);
                                end
`endif
                            end
                            SAMPLE: begin
                                if (r_samp == SW'(SAMPLE_DELAY)) begin
                                    r_shift <= w_shift_next[62:0];
                                    r_bits  <= w_bits_next;
`ifdef GC_RX_TIMEOUT_EN
                                    r_tcnt  <= '0;
`endif
                                    if (w_last) begin
                                        r_state <= IDLE;
                                        if (r_len24) begin
                                            r_id <= w_shift_next[23:0];
                                            r_iv <= 1'b1;
                                        end else begin
                                            r_data <= w_shift_next;
                                            r_dv   <= 1'b1;
                                        end
                                    end else begin
                                        r_state <= ARMED;
                                    end
                                end else begin
                                    r_samp <= r_samp + SW'(1);
                                end
                            end
                            default: r_state <= IDLE;
                        endcase
                    end
                end
            end

            assign rx_data[64*gi +: 64] = r_data;
            assign rx_id[24*gi +: 24]   = r_id;
            assign data_valid[gi]       = r_dv;
            assign id_valid[gi]         = r_iv;
            assign busy[gi]             = (r_state != IDLE);
`ifdef GC_RX_TIMEOUT_EN
            assign rx_timeout[gi]       = r_to;
`else
            assign rx_timeout[gi]       = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_gc_rx_multi.sv
// Testbench for gc_rx_multi: frame-level reference model plus literal checks.
module tb_gc_rx_multi;
    localparam int CH = 4;
    localparam int SD = 8;
    localparam int TO = 2000;
    localparam logic [63:0] NEUTRAL = 64'h8080808080800000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CH-1:0] data_in = '1;
    logic [CH-1:0] send = '0;
    logic [CH-1:0] mode = '0;
    logic [64*CH-1:0] rx_data;
    logic [24*CH-1:0] rx_id;
    logic [CH-1:0] data_valid, id_valid, rx_timeout, busy;

    gc_rx_multi #(.CHANNELS(CH), .SAMPLE_DELAY(SD), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .send(send), .mode(mode),
        .rx_data(rx_data), .rx_id(rx_id), .data_valid(data_valid),
        .id_valid(id_valid), .rx_timeout(rx_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_fall = 0;

    // Reference model: last reported frames and scheduled report events.
    logic [63:0] exp_data [CH];
    logic [23:0] exp_id [CH];
    int          due_cyc [CH];
    bit          due_id [CH];
    logic [63:0] due_val [CH];
    int          to_cyc [CH];
    int          n_dv [CH] = '{default: 0};
    int          n_iv [CH] = '{default: 0};
    int          n_to [CH] = '{default: 0};
    int          dv_last [CH] = '{default: 0};
    logic [63:0] frame_val [CH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            exp_data[c] = NEUTRAL;
            exp_id[c]   = '0;
            due_cyc[c]  = -1;
            to_cyc[c]   = -1;
        end
    endtask

    // Compare process: checks every output of every channel each cycle.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                model_reset();
                chk("busy_in_reset", 64'(busy), 64'd0);
            end
            for (int c = 0; c < CH; c++) begin
                logic edv, eiv, eto;
                edv = (due_cyc[c] == cyc) && !due_id[c];
                eiv = (due_cyc[c] == cyc) && due_id[c];
                if (due_cyc[c] == cyc) begin
                    if (due_id[c]) exp_id[c] = due_val[c][23:0];
                    else           exp_data[c] = due_val[c];
                    due_cyc[c] = -1;
                end
                eto = (to_cyc[c] == cyc);
                if (eto) to_cyc[c] = -1;
                chk($sformatf("data_valid[%0d]", c), 64'(data_valid[c]), 64'(edv));
                chk($sformatf("id_valid[%0d]", c), 64'(id_valid[c]), 64'(eiv));
                chk($sformatf("rx_timeout[%0d]", c), 64'(rx_timeout[c]), 64'(eto));
                chk($sformatf("rx_data[%0d]", c), rx_data[64*c +: 64], exp_data[c]);
                chk($sformatf("rx_id[%0d]", c), 64'(rx_id[24*c +: 24]), 64'(exp_id[c]));
                if (data_valid[c]) begin n_dv[c]++; dv_last[c] = cyc; end
                if (id_valid[c]) n_iv[c]++;
                if (rx_timeout[c]) n_to[c]++;
            end
        end
    end

    // Pulse send on the masked channels with the given frame mode.
    task automatic arm(input logic [CH-1:0] m, input bit md);
        @(negedge clk);
        for (int c = 0; c < CH; c++) if (m[c]) begin mode[c] = md; send[c] = 1'b1; end
        repeat (3) @(negedge clk);
        send = send & ~m;
        repeat (4) @(negedge clk);
    endtask

    // Drive the first nbits of frame_val on masked channels, 16-cycle cells:
    // '1' = 3 cycles low, '0' = 13 cycles low. A full frame schedules its report
    // at sync latency (3) plus SAMPLE_DELAY after the last falling edge.
    task automatic drive_bits(input logic [CH-1:0] m, input bit md, input int nbits);
        int len;
        int idx;
        len = md ? 24 : 64;
        for (int i = 0; i < nbits; i++) begin
            idx = len - 1 - i;
            for (int t = 0; t < 16; t++) begin
                @(negedge clk);
                for (int c = 0; c < CH; c++)
                    if (m[c]) data_in[c] = (t < (frame_val[c][idx] ? 3 : 13)) ? 1'b0 : 1'b1;
                if (t == 0) begin
                    last_fall = cyc;
                    if (i == len - 1)
                        for (int c = 0; c < CH; c++) if (m[c]) begin
                            due_cyc[c] = cyc + SD + 3;
                            due_id[c]  = md;
                            due_val[c] = md ? {40'd0, frame_val[c][23:0]} : frame_val[c];
                        end
                end
            end
        end
    endtask

    initial begin
        int cnt;
        logic [CH-1:0] m;
        bit md;

        repeat (3) @(negedge clk);
        chk("reset_rx_data", rx_data[255:192], NEUTRAL);
        chk("reset_rx_data_low", rx_data[63:0], 64'h8080808080800000);
        chk("reset_rx_id", 64'(rx_id), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // Button frame on channel 0.
        frame_val[0] = 64'h0080_7F80_8080_1A2B;
        arm(4'b0001, 1'b0);
        chk("busy0_armed", 64'(busy[0]), 64'd1);
        drive_bits(4'b0001, 1'b0, 64);
        repeat (20) @(negedge clk);
        chk("lane0_value", rx_data[63:0], 64'h0080_7F80_8080_1A2B);
        chk("other_lanes", 64'(rx_data[255:64] == {3{NEUTRAL}}), 64'd1);
        chk("dv0_count", 64'(n_dv[0]), 64'd1);
        chk("busy0_done", 64'(busy[0]), 64'd0);

        // ID frame on channel 1.
        frame_val[1] = 64'h0A0B0C;
        arm(4'b0010, 1'b1);
        drive_bits(4'b0010, 1'b1, 24);
        repeat (20) @(negedge clk);
        chk("lane1_id", 64'(rx_id[47:24]), 64'h0A0B0C);
        chk("iv1_count", 64'(n_iv[1]), 64'd1);
        chk("lane1_data", rx_data[127:64], NEUTRAL);

        // Simultaneous frames on channels 2 and 3.
        frame_val[2] = {$urandom, $urandom};
        frame_val[3] = {$urandom, $urandom};
        arm(4'b1100, 1'b0);
        drive_bits(4'b1100, 1'b0, 64);
        repeat (20) @(negedge clk);
        chk("lane2_value", rx_data[191:128], frame_val[2]);
        chk("lane3_value", rx_data[255:192], frame_val[3]);
        chk("dv23_same_cycle", 64'(dv_last[2]), 64'(dv_last[3]));

        // Falling edges while idle are ignored.
        drive_bits(4'b0001, 1'b0, 3);
        chk("idle_edges_busy", 64'(busy[0]), 64'd0);

`ifdef GC_RX_TIMEOUT_EN
        frame_val[0] = {$urandom, $urandom};
        cnt = n_to[0];
        arm(4'b0001, 1'b0);
        drive_bits(4'b0001, 1'b0, 10);
        to_cyc[0] = last_fall + SD + 3 + TO;
        repeat (TO + 20) @(negedge clk);
        chk("timeout_count", 64'(n_to[0] - cnt), 64'd1);
        chk("timeout_busy", 64'(busy[0]), 64'd0);
`endif

        // Reset mid-frame.
        cnt = n_dv[0];
        frame_val[0] = {$urandom, $urandom};
        arm(4'b0001, 1'b0);
        drive_bits(4'b0001, 1'b0, 30);
        chk("busy_before_rst", 64'(busy[0]), 64'd1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        chk("rst_lane0", rx_data[63:0], 64'h8080808080800000);
        chk("rst_no_dv", 64'(n_dv[0] - cnt), 64'd0);

        // Send reasserted after 40 bits, then a full frame.
        cnt = n_dv[0];
        frame_val[0] = 64'hFFFF_0000_AAAA_5555;
        arm(4'b0001, 1'b0);
        drive_bits(4'b0001, 1'b0, 40);
        frame_val[0] = 64'h1234_5678_9ABC_DEF0;
        arm(4'b0001, 1'b0);
        drive_bits(4'b0001, 1'b0, 64);
        repeat (20) @(negedge clk);
        chk("rearm_value", rx_data[63:0], 64'h1234_5678_9ABC_DEF0);
        chk("rearm_dv_count", 64'(n_dv[0] - cnt), 64'd1);

        // Randomised frames on random channel sets.
        for (int k = 0; k < 6; k++) begin
            m  = CH'($urandom_range(1, 15));
            md = 1'($urandom_range(0, 1));
            for (int c = 0; c < CH; c++) frame_val[c] = {$urandom, $urandom};
            arm(m, md);
            drive_bits(m, md, md ? 24 : 64);
            repeat (20) @(negedge clk);
            chk($sformatf("rand%0d_idle", k), 64'(busy), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
